// File: rtl/tlb_ctrl_pkg.sv
// Shared definitions for the TLB-management controller: TLB geometry,
// TLB op codes, FSM state encoding and EntryHi field positions.
package tlb_ctrl_pkg;

  localparam int TLBNUM = 16;
  localparam int IDX_W  = 4;

  localparam logic [1:0] TLBOP_P  = 2'b00;
  localparam logic [1:0] TLBOP_R  = 2'b01;
  localparam logic [1:0] TLBOP_WI = 2'b10;
  localparam logic [1:0] TLBOP_WR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PROBE   = 3'd1,
    ST_PDONE   = 3'd2,
    ST_READ    = 3'd3,
    ST_RDONE   = 3'd4,
    ST_WRITE   = 3'd5,
    ST_REFETCH = 3'd6
  } tlb_state_e;

  localparam int EHI_VPN2_HI = 31;
  localparam int EHI_VPN2_LO = 13;
  localparam int EHI_ASID_HI = 7;
  localparam int EHI_ASID_LO = 0;

endpackage

// File: rtl/tlb_random_cnt.sv
// Free-running CP0 Random counter: counts down every cycle from TLBNUM-1,
// wrapping from 0 back to TLBNUM-1. Not affected by TLB operations.
module tlb_random_cnt
  import tlb_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(TLBNUM - 1);

  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] cnt_d;

  // Down-count with explicit wrap at zero.
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (cnt_q == '0) begin
      cnt_d = TOP;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= TOP;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign random = cnt_q;

endmodule

// File: rtl/tlb_ctrl.sv
// TLB-management sequencer for TLBP/TLBR/TLBWI/TLBWR, search-port mux
// between data-side translation and probes, and post-write refetch.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | ready for an op; search port owned by data side
// ST_PROBE   | search port driven from EntryHi; hit result captured
// ST_PDONE   | probe result written to CP0 Index; op done
// ST_READ    | TLB read port addressed by CP0 Index
// ST_RDONE   | read data written to EntryHi/EntryLo0/1; op done
// ST_WRITE   | one-cycle TLB write (Index or latched Random)
// ST_REFETCH | refetch pulse at op_pc+4; op done
module tlb_ctrl
  import tlb_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [31:0]      op_pc,
  input  logic             op_flush,
  output logic             op_ready,
  output logic             op_done,
  input  logic [31:0]      cp0_entryhi,
  input  logic [IDX_W-1:0] cp0_index,
  output logic             p_we,
  output logic             p_found,
  output logic [IDX_W-1:0] p_index,
  output logic             r_we,
  output logic [IDX_W-1:0] r_index,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_windex,
  input  logic             dl_valid,
  input  logic [18:0]      dl_vpn2,
  input  logic             dl_odd,
  input  logic [7:0]       dl_asid,
  output logic             dl_ready,
  output logic [18:0]      s1_vpn2,
  output logic             s1_odd,
  output logic [7:0]       s1_asid,
  input  logic             s1_found,
  input  logic [IDX_W-1:0] s1_index,
  output logic             refetch,
  output logic [31:0]      refetch_pc,
  output logic [IDX_W-1:0] random
);

  tlb_state_e       state_q, state_d;
  logic [31:0]      rpc_q, rpc_d;
  logic             is_wr_q, is_wr_d;
  logic [IDX_W-1:0] wr_rnd_q, wr_rnd_d;
  logic             found_q, found_d;
  logic [IDX_W-1:0] pidx_q, pidx_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic             accept;

  // EntryHi bits between ASID and VPN2 and the lookup valid play no part here.
  logic unused_ok;
  assign unused_ok = ^{cp0_entryhi[EHI_VPN2_LO-1:EHI_ASID_HI+1], dl_valid};

  tlb_random_cnt u_random (
    .clk    (clk),
    .reset  (reset),
    .random (random)
  );

  assign accept = op_valid & (state_q == ST_IDLE) & ~op_flush;

  // Next-state logic and per-op latches.
  always_comb begin
    state_d  = state_q;
    rpc_d    = rpc_q;
    is_wr_d  = is_wr_q;
    wr_rnd_d = wr_rnd_q;
    found_d  = found_q;
    pidx_d   = pidx_q;
    ridx_d   = ridx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rpc_d    = op_pc + 32'd4;
          is_wr_d  = (op_code == TLBOP_WR);
          wr_rnd_d = random;
          unique case (op_code)
            TLBOP_P: state_d = ST_PROBE;
            TLBOP_R: state_d = ST_READ;
            default: state_d = ST_WRITE;
          endcase
        end
      end
      ST_PROBE: begin
        found_d = s1_found;
        pidx_d  = s1_index;
        state_d = ST_PDONE;
      end
      ST_READ: begin
        ridx_d  = cp0_index;
        state_d = ST_RDONE;
      end
      ST_WRITE:   state_d = ST_REFETCH;
      ST_PDONE,
      ST_RDONE,
      ST_REFETCH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and latch registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rpc_q    <= '0;
      is_wr_q  <= 1'b0;
      wr_rnd_q <= '0;
      found_q  <= 1'b0;
      pidx_q   <= '0;
      ridx_q   <= '0;
    end else begin
      state_q  <= state_d;
      rpc_q    <= rpc_d;
      is_wr_q  <= is_wr_d;
      wr_rnd_q <= wr_rnd_d;
      found_q  <= found_d;
      pidx_q   <= pidx_d;
      ridx_q   <= ridx_d;
    end
  end

  // State-decoded outputs and the search-port mux.
  always_comb begin
    op_ready   = (state_q == ST_IDLE);
    op_done    = 1'b0;
    p_we       = 1'b0;
    p_found    = 1'b0;
    p_index    = '0;
    r_we       = 1'b0;
    r_index    = '0;
    tlb_we     = 1'b0;
    tlb_windex = '0;
    refetch    = 1'b0;
    dl_ready   = 1'b1;
    s1_vpn2    = dl_vpn2;
    s1_odd     = dl_odd;
    s1_asid    = dl_asid;
    unique case (state_q)
      ST_PROBE: begin
        dl_ready = 1'b0;
        s1_vpn2  = cp0_entryhi[EHI_VPN2_HI:EHI_VPN2_LO];
        s1_odd   = 1'b0;
        s1_asid  = cp0_entryhi[EHI_ASID_HI:EHI_ASID_LO];
      end
      ST_PDONE: begin
        p_we    = 1'b1;
        p_found = found_q;
        p_index = pidx_q;
        op_done = 1'b1;
      end
      ST_READ: r_index = cp0_index;
      ST_RDONE: begin
        r_index = ridx_q;
        r_we    = 1'b1;
        op_done = 1'b1;
      end
      ST_WRITE: begin
        tlb_we     = 1'b1;
        tlb_windex = is_wr_q ? wr_rnd_q : cp0_index;
      end
      ST_REFETCH: begin
        refetch = 1'b1;
        op_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign refetch_pc = rpc_q;

endmodule
